// File: rtl/tx_defs.sv
// Shared definitions for the request dispatch stage: FSM encoding,
// error codes and the wait-counter width helper.
package tx_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WAIT_FREE = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_ERR       = 3'd4
    } state_t;

    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Width of a counter that must hold values up to timeout; never below 1.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/tx_addr_decode.sv
// Maps a global address onto a switch index, a range flag and a one-hot
// select vector. Purely combinational.
module tx_addr_decode
    import tx_defs::*;
#(
    parameter int NUM_SW_INST  = 5,
    parameter int ADDR_WIDTH   = 8,
    parameter int SW_SPAN_LOG2 = 4,
    parameter int IDX_W        = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1
) (
    input  logic [ADDR_WIDTH-1:0]  addr,
    output logic [IDX_W-1:0]       idx,
    output logic                   in_range,
    output logic [NUM_SW_INST-1:0] sel
);

    localparam int UPPER_W = ADDR_WIDTH - SW_SPAN_LOG2;

    logic [UPPER_W-1:0] upper;

    // The range test uses every upper address bit so that a large address
    // cannot alias onto a valid switch when idx is truncated.
    always_comb begin
        upper    = addr[ADDR_WIDTH-1:SW_SPAN_LOG2];
        in_range = (32'(upper) < NUM_SW_INST);
        idx      = in_range ? upper[IDX_W-1:0] : '0;
        sel      = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            sel[i] = in_range && (32'(upper) == i);
        end
    end

endmodule

// File: rtl/tx_dispatch.sv
// Request dispatch stage: accepts one host request, waits for the target
// switch to go idle, then issues a one-cycle select or an error response.
module tx_dispatch
    import tx_defs::*;
#(
    parameter int NUM_SW_INST  = 5,
    parameter int W_WIDTH      = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int SW_SPAN_LOG2 = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [7:0]              req_op_id,
    input  logic                    req_wr,
    input  logic [W_WIDTH-1:0]      req_wdata,
    input  logic [NUM_SW_INST-1:0]  sw_busy,
    output logic [NUM_SW_INST-1:0]  sel_en,
    output logic [7:0]              op_id_out,
    output logic [SW_SPAN_LOG2-1:0] sw_addr,
    output logic                    sw_wr,
    output logic [W_WIDTH-1:0]      sw_wdata,
    output logic                    err_valid,
    output logic [7:0]              err_op_id,
    output logic [1:0]              err_code
);

    localparam int IDX_W      = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
    localparam int BUSY_EXT_W = 1 << IDX_W;
    localparam int CNT_W      = cnt_width(TIMEOUT);

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [1:0]              code_q, code_next;

    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [7:0]              lat_op_id;
    logic                    lat_wr;
    logic [W_WIDTH-1:0]      lat_wdata;

    logic [IDX_W-1:0]        idx;
    logic                    in_range;
    logic [NUM_SW_INST-1:0]  sel_vec;
    logic [BUSY_EXT_W-1:0]   busy_ext;
    logic                    target_busy;

    tx_addr_decode #(
        .NUM_SW_INST  (NUM_SW_INST),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .SW_SPAN_LOG2 (SW_SPAN_LOG2),
        .IDX_W        (IDX_W)
    ) u_decode (
        .addr     (lat_addr),
        .idx      (idx),
        .in_range (in_range),
        .sel      (sel_vec)
    );

    // Busy flag of the decoded target, padded so idx can never index past it.
    always_comb begin
        busy_ext    = BUSY_EXT_W'(sw_busy);
        target_busy = busy_ext[idx];
    end

    // State, wait counter and pending error code registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            code_q <= '0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            code_q <= code_next;
        end
    end

    // Capture the request fields on acceptance; they stay stable until the
    // next acceptance because req_ready is low outside IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_op_id <= '0;
            lat_wr    <= 1'b0;
            lat_wdata <= '0;
        end else if (state == ST_IDLE && req_valid) begin
            lat_addr  <= req_addr;
            lat_op_id <= req_op_id;
            lat_wr    <= req_wr;
            lat_wdata <= req_wdata;
        end
    end

    // Next-state logic and output decode from registered state only.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code_q;
        req_ready  = 1'b0;
        sel_en     = '0;
        op_id_out  = '0;
        sw_addr    = '0;
        sw_wr      = 1'b0;
        sw_wdata   = '0;
        err_valid  = 1'b0;
        err_op_id  = '0;
        err_code   = '0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!in_range) begin
                    state_next = ST_ERR;
                    code_next  = ERR_RANGE;
                end else if (!target_busy) begin
                    state_next = ST_ISSUE;
                end else begin
                    state_next = ST_WAIT_FREE;
                    cnt_next   = '0;
                end
            end
            ST_WAIT_FREE: begin
                if (!target_busy) begin
                    state_next = ST_ISSUE;
                end else if (TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_ERR;
                    code_next  = ERR_TIMEOUT;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_ISSUE: begin
                sel_en     = sel_vec;
                op_id_out  = lat_op_id;
                sw_addr    = lat_addr[SW_SPAN_LOG2-1:0];
                sw_wr      = lat_wr;
                sw_wdata   = lat_wdata;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                err_valid  = 1'b1;
                err_op_id  = lat_op_id;
                err_code   = code_q;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/tx_dispatch.md
Name: tx_dispatch

Overview:
Request-side stage that sits directly upstream of rx_top. It accepts one host request at a time (address, op_id, write flag, write data) and decodes the address to a switch instance. It waits until that switch's sw_busy is low, then issues a one-cycle one-hot sel_en together with the op_id; rx_top uses both to track the outstanding operation. Out-of-range addresses and switches that stay busy too long produce an error response instead of a select.

Parameters:
NUM_SW_INST, 5, number of switch instances (matches rx_top).
W_WIDTH, 8, write-data width.
ADDR_WIDTH, 8, request address width.
SW_SPAN_LOG2, 4, log2 of the address window per switch (16 addresses per switch).
TIMEOUT, 16, maximum cycles spent in WAIT_FREE; 0 disables the timeout.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
req_valid  in  1  request valid.
req_ready  out  1  stage can accept a request.
req_addr  in  ADDR_WIDTH  global address.
req_op_id  in  8  operation tag.
req_wr  in  1  1 = write, 0 = read.
req_wdata  in  W_WIDTH  write data.
sw_busy  in  NUM_SW_INST  per-switch busy flag, from rx_top.
sel_en  out  NUM_SW_INST  one-hot issue strobe; feeds rx_top sel_en.
op_id_out  out  8  tag issued with sel_en; feeds rx_top op_id.
sw_addr  out  SW_SPAN_LOG2  local offset, req_addr[SW_SPAN_LOG2-1:0].
sw_wr  out  1  write flag issued with sel_en.
sw_wdata  out  W_WIDTH  write data issued with sel_en.
err_valid  out  1  one-cycle error strobe.
err_op_id  out  8  tag of the failed request.
err_code  out  2  01 = address out of range, 10 = busy timeout.

Behaviour:
- Reset (rst high at an edge): state goes to IDLE and the wait counter to 0. All outputs read 0 except req_ready, which is 1 in the first cycle after reset. Any pending request is discarded silently, with no sel_en and no err.
- FSM states: IDLE, DECODE, WAIT_FREE, ISSUE, ERR.
- IDLE: req_ready=1. On the edge where req_valid&&req_ready, latch addr, op_id, wr and wdata, then go to DECODE. req_ready=0 in every other state, so there is no back-to-back acceptance.
- DECODE: idx = latched_addr >> SW_SPAN_LOG2.
  - idx >= NUM_SW_INST → ERR, code 01.
  - Otherwise, sw_busy[idx]==0 → ISSUE.
  - Otherwise → WAIT_FREE, with the counter cleared.
- WAIT_FREE: sample sw_busy[idx] every cycle.
  - Low → ISSUE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1 → ERR, code 10.
  - Else the counter increments.
- ISSUE: for exactly one cycle, sel_en[idx]=1 (one-hot) with op_id_out, sw_addr, sw_wr and sw_wdata valid. Next state is IDLE.
- ERR: err_valid=1 for exactly one cycle with err_op_id and err_code valid; sel_en=0. Next state is IDLE.
- Outputs are decoded from registered state and latched fields only; nothing is combinational from inputs. op_id_out, sw_addr, sw_wr and sw_wdata read 0 when sel_en==0. err_op_id and err_code read 0 when err_valid==0.
- Latency, free switch: acceptance at edge E0, DECODE in the next cycle, sel_en high in the cycle after E1, req_ready high again after E2.
- Minimum spacing between two issues is 3 cycles. This leaves rx_top one cycle to register sw_busy before the next DECODE samples it.
- sw_busy changing while in DECODE or WAIT_FREE: the value sampled at the decision edge is the one that counts.
- sel_en and err_valid are never high together. sel_en has at most one bit set.

Decomposition:
- Shared package/header tx_defs: state encodings (3-bit), ERR_RANGE=2'b01, ERR_TIMEOUT=2'b10, and the counter width $clog2(TIMEOUT+1) (minimum 1).
- One combinational sub-module, tx_addr_decode: takes addr and produces idx ($clog2(NUM_SW_INST) bits), in_range and the one-hot select vector.

Test Plan:
(NUM_SW_INST=5, SW_SPAN_LOG2=4, TIMEOUT=16 for all scenarios.)
1. Reset: hold rst for 2 cycles, then release → all outputs 0, req_ready=1, no sel_en for 10 idle cycles.
2. Request addr=0x23, op_id=0x5A, wr=1, wdata=0xC3, sw_busy=0 → sel_en=5'b00100 for exactly one cycle, two cycles after acceptance. That cycle carries op_id_out=0x5A, sw_addr=0x3, sw_wr=1, sw_wdata=0xC3. req_ready returns one cycle later.
3. Request addr=0x50, op_id=0x11 → err_valid for one cycle with err_code=01 and err_op_id=0x11; sel_en stays 0 throughout.
4. sw_busy[1]=1, request addr=0x1F, drop busy after 5 cycles → no sel_en while busy is high. Then sel_en=5'b00010 in the cycle after busy is sampled low, with sw_addr=0xF.
5. sw_busy[4] held at 1, request addr=0x40, op_id=0x77 → err_valid after 16 cycles in WAIT_FREE with err_code=10 and err_op_id=0x77; no sel_en.
6. rst pulsed for 1 cycle while in WAIT_FREE (busy held), then busy released → no sel_en and no err_valid; req_ready=1 in the cycle after reset.
